ring_phase_monitor: RTL and testbench

//  Downstream consumer of the 8-bit one-hot ring counter. Samples the ring word, encodes the hot

---
 rtl/ring_phase_monitor_pkg.sv | 19 +
 rtl/ring_phase_monitor_if.sv | 32 +++
 rtl/ring_phase_monitor_onehot_encoder.sv | 23 ++
 rtl/ring_phase_monitor.sv | 150 +++++++++++++++
 tb/tb_ring_phase_monitor.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_phase_monitor_pkg.sv
// Shared definitions for the ring phase monitor: FSM encoding and default widths.
package ring_phase_monitor_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_LOCK_COUNT = 2;
    localparam int unsigned DEF_REV_W      = 16;
    localparam int unsigned DEF_ERR_W      = 8;

    // Confirm counter only needs to reach LOCK_COUNT (at most 15).
    localparam int unsigned CONFIRM_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

endpackage

// File: rtl/ring_phase_monitor_if.sv
// Ring sample inputs and phase/status outputs of the ring phase monitor.
interface ring_phase_monitor_if
    import ring_phase_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned REV_W = DEF_REV_W,
    parameter int unsigned ERR_W = DEF_ERR_W
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] ring_in;
    logic             sample_en;
    logic             clear_err;
    logic [IDX_W-1:0] phase_idx;
    logic             phase_ok;
    logic             locked;
    logic             rev_tick;
    logic [REV_W-1:0] rev_count;
    logic             err_sticky;
    logic [ERR_W-1:0] err_count;

    modport master (
        output ring_in, sample_en, clear_err,
        input  phase_idx, phase_ok, locked, rev_tick, rev_count, err_sticky, err_count
    );

    modport slave (
        input  ring_in, sample_en, clear_err,
        output phase_idx, phase_ok, locked, rev_tick, rev_count, err_sticky, err_count
    );

endinterface

// File: rtl/ring_phase_monitor_onehot_encoder.sv
// Combinational one-hot to binary encoder with an exactly-one-bit-set flag.
module onehot_encoder #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx_c,
    output logic             is_onehot_c
);

    // OR of the positions of all set bits; only meaningful when is_onehot_c.
    always_comb begin
        idx_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx_c = idx_c | IDX_W'(i);
            end
        end
    end

    assign is_onehot_c = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/ring_phase_monitor.sv
// Tracks a rotating one-hot ring: phase index, lock FSM, revolution and fault counters.
module ring_phase_monitor
    import ring_phase_monitor_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int unsigned REV_W      = DEF_REV_W,
    parameter int unsigned ERR_W      = DEF_ERR_W
) (
    input  logic               clk,
    input  logic               reset,
    ring_phase_monitor_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = CONFIRM_CNT_W;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ok_q, ok_d;
    logic             locked_q, locked_d;
    logic             tick_q, tick_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic             sticky_q, sticky_d;
    logic [ERR_W-1:0] errc_q, errc_d;

    logic [IDX_W-1:0] enc_idx_c;
    logic             enc_onehot_c;
    logic             step_ok_c;
    logic             fault_c;
    logic [ERR_W-1:0] err_base_c;

    onehot_encoder #(
        .WIDTH (WIDTH)
    ) u_enc (
        .vec         (bus.ring_in),
        .idx_c       (enc_idx_c),
        .is_onehot_c (enc_onehot_c)
    );

    // Ring rotates toward lower bit positions; IDX_W-bit subtraction wraps 0 -> WIDTH-1.
    assign step_ok_c = enc_onehot_c && (enc_idx_c == (idx_q - IDX_W'(1)));

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_HUNT;
            cnt_q    <= '0;
            idx_q    <= '0;
            ok_q     <= 1'b0;
            locked_q <= 1'b0;
            tick_q   <= 1'b0;
            rev_q    <= '0;
            sticky_q <= 1'b0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ok_q     <= ok_d;
            locked_q <= locked_d;
            tick_q   <= tick_d;
            rev_q    <= rev_d;
            sticky_q <= sticky_d;
            errc_q   <= errc_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ok_d       = ok_q;
        tick_d     = 1'b0;
        rev_d      = rev_q;
        sticky_d   = sticky_q;
        errc_d     = errc_q;
        fault_c    = 1'b0;
        err_base_c = bus.clear_err ? '0 : errc_q;

        if (bus.clear_err) begin
            sticky_d = 1'b0;
            errc_d   = '0;
        end

        if (state_q == ST_FAULT) begin
            state_d = ST_HUNT;
        end else if (bus.sample_en) begin
            ok_d = enc_onehot_c;
            if (enc_onehot_c) begin
                idx_d = enc_idx_c;
            end

            unique case (state_q)
                ST_HUNT: begin
                    if (enc_onehot_c) begin
                        state_d = ST_CONFIRM;
                        cnt_d   = '0;
                    end
                end
                ST_CONFIRM: begin
                    if (step_ok_c) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if ((cnt_q + CNT_W'(1)) >= CNT_W'(LOCK_COUNT)) begin
                            state_d = ST_LOCKED;
                        end
                    end else if (enc_onehot_c) begin
                        cnt_d = '0;
                    end else begin
                        state_d = ST_HUNT;
                        cnt_d   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (step_ok_c) begin
                        if (enc_idx_c == '0) begin
                            tick_d = 1'b1;
                            rev_d  = rev_q + REV_W'(1);
                        end
                    end else begin
                        state_d = ST_FAULT;
                        fault_c = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        // A fault in the same cycle as clear_err still records itself.
        if (fault_c) begin
            sticky_d = 1'b1;
            errc_d   = (&err_base_c) ? err_base_c : err_base_c + ERR_W'(1);
        end

        locked_d = (state_d == ST_LOCKED);
    end

    assign bus.phase_idx  = idx_q;
    assign bus.phase_ok   = ok_q;
    assign bus.locked     = locked_q;
    assign bus.rev_tick   = tick_q;
    assign bus.rev_count  = rev_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_count  = errc_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor: directed scenarios plus randomized ring traffic.
module tb_ring_phase_monitor;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned LOCK_COUNT = 2;
    localparam int unsigned REV_W      = 16;
    localparam int unsigned ERR_W      = 8;
    localparam int unsigned IDX_W      = 3;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             ok;
        logic             locked;
        logic             tick;
        logic [REV_W-1:0] rev;
        logic             sticky;
        logic [ERR_W-1:0] errc;
    } obs_t;

    typedef enum int {M_SEARCH, M_CONFIRM, M_TRACK, M_RECOVER} mphase_t;

    logic clk;
    logic reset;

    ring_phase_monitor_if #(.WIDTH(WIDTH), .REV_W(REV_W), .ERR_W(ERR_W)) bus ();

    ring_phase_monitor #(
        .WIDTH      (WIDTH),
        .LOCK_COUNT (LOCK_COUNT),
        .REV_W      (REV_W),
        .ERR_W      (ERR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t    exp_q[$];
    int      n_tests;
    int      n_fail;

    mphase_t m_phase;
    int      m_steps;
    int      m_idx;
    bit      m_ok;
    bit      m_tick;
    int      m_rev;
    bit      m_sticky;
    int      m_errc;

    function automatic logic [7:0] hot(input int i);
        logic [7:0] v;
        v = 8'd1;
        return v << i;
    endfunction

    // Reference model: applies one clock edge worth of behaviour and queues the expected outputs.
    task automatic model(input bit rst, input bit se, input bit ce, input logic [7:0] ring);
        int   pos;
        bit   oh;
        bit   legal;
        bit   fault;
        obs_t e;
        fault  = 1'b0;
        m_tick = 1'b0;
        if (rst) begin
            m_phase = M_SEARCH; m_steps = 0; m_idx = 0; m_ok = 1'b0;
            m_rev = 0; m_sticky = 1'b0; m_errc = 0;
        end else begin
            if (ce) begin
                m_sticky = 1'b0;
                m_errc   = 0;
            end
            if (m_phase == M_RECOVER) begin
                m_phase = M_SEARCH;
            end else if (se) begin
                oh  = ($countones(ring) == 1);
                pos = 0;
                for (int i = 0; i < int'(WIDTH); i++) if (ring[i]) pos = i;
                legal = oh && (pos == (m_idx + int'(WIDTH) - 1) % int'(WIDTH));
                m_ok  = oh;
                case (m_phase)
                    M_SEARCH: if (oh) begin m_phase = M_CONFIRM; m_steps = 0; end
                    M_CONFIRM: begin
                        if (legal) begin
                            m_steps++;
                            if (m_steps >= int'(LOCK_COUNT)) m_phase = M_TRACK;
                        end else if (oh) m_steps = 0;
                        else m_phase = M_SEARCH;
                    end
                    M_TRACK: begin
                        if (legal) begin
                            if (pos == 0) begin
                                m_tick = 1'b1;
                                m_rev  = (m_rev + 1) % 65536;
                            end
                        end else begin
                            m_phase = M_RECOVER;
                            fault   = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (oh) m_idx = pos;
            end
            if (fault) begin
                m_sticky = 1'b1;
                if (m_errc < 255) m_errc++;
            end
        end
        e.idx    = IDX_W'(m_idx);
        e.ok     = m_ok;
        e.locked = (m_phase == M_TRACK);
        e.tick   = m_tick;
        e.rev    = REV_W'(m_rev);
        e.sticky = m_sticky;
        e.errc   = ERR_W'(m_errc);
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit rst, input bit se, input bit ce, input logic [7:0] ring);
        @(negedge clk);
        reset         = rst;
        bus.sample_en = se;
        bus.clear_err = ce;
        bus.ring_in   = ring;
        model(rst, se, ce, ring);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every edge with an outstanding expectation is compared against the DUT.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.idx    = bus.phase_idx;
                a.ok     = bus.phase_ok;
                a.locked = bus.locked;
                a.tick   = bus.rev_tick;
                a.rev    = bus.rev_count;
                a.sticky = bus.err_sticky;
                a.errc   = bus.err_count;
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL obs t=%0t got idx=%0d ok=%0b lk=%0b tk=%0b rev=%0d st=%0b err=%0d required idx=%0d ok=%0b lk=%0b tk=%0b rev=%0d st=%0b err=%0d",
                             $time, a.idx, a.ok, a.locked, a.tick, a.rev, a.sticky, a.errc,
                             e.idx, e.ok, e.locked, e.tick, e.rev, e.sticky, e.errc);
                end
            end
        end
    end

    initial begin
        int         p;
        int         np;
        int         r;
        bit         rs;
        bit         rc;
        bit         rr;
        logic [7:0] ring;

        n_tests = 0;
        n_fail  = 0;
        m_phase = M_SEARCH; m_steps = 0; m_idx = 0; m_ok = 1'b0; m_tick = 1'b0;
        m_rev = 0; m_sticky = 1'b0; m_errc = 0;
        reset = 1'b1;
        bus.sample_en = 1'b0;
        bus.clear_err = 1'b0;
        bus.ring_in   = '0;

        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 8'h01);
        settle();
        check_now("rst_locked", int'(bus.locked), 0);
        check_now("rst_phase_ok", int'(bus.phase_ok), 0);

        // Acquire lock on 01,80,40 then one more legal step.
        drive(1'b0, 1'b1, 1'b0, 8'h01);
        drive(1'b0, 1'b1, 1'b0, 8'h80);
        drive(1'b0, 1'b1, 1'b0, 8'h40);
        settle();
        check_now("t1_locked", int'(bus.locked), 1);
        drive(1'b0, 1'b1, 1'b0, 8'h20);
        settle();
        check_now("t1_idx", int'(bus.phase_idx), 5);

        // Sixteen legal steps: two passes through index 0.
        p = 5;
        for (int i = 0; i < 16; i++) begin
            p = (p + 7) % 8;
            drive(1'b0, 1'b1, 1'b0, hot(p));
        end
        settle();
        check_now("t2_rev", int'(bus.rev_count), 2);
        check_now("t2_err", int'(bus.err_count), 0);

        // Multi-hot corruption while locked at index 4.
        drive(1'b0, 1'b1, 1'b0, hot(4));
        drive(1'b0, 1'b1, 1'b0, 8'h18);
        settle();
        check_now("t3_ok", int'(bus.phase_ok), 0);
        check_now("t3_sticky", int'(bus.err_sticky), 1);
        check_now("t3_err", int'(bus.err_count), 1);
        check_now("t3_locked", int'(bus.locked), 0);
        drive(1'b0, 1'b1, 1'b0, 8'h18);

        // Repeated wrong-direction faults saturate the error counter.
        for (int i = 0; i < 260; i++) begin
            drive(1'b0, 1'b1, 1'b0, hot(6));
            drive(1'b0, 1'b1, 1'b0, hot(5));
            drive(1'b0, 1'b1, 1'b0, hot(4));
            drive(1'b0, 1'b1, 1'b0, hot(5));
            drive(1'b0, 1'b0, 1'b0, 8'h00);
        end
        settle();
        check_now("t4_err_sat", int'(bus.err_count), 255);

        // clear_err coincident with a fault, then clear_err alone.
        drive(1'b0, 1'b1, 1'b0, hot(6));
        drive(1'b0, 1'b1, 1'b0, hot(5));
        drive(1'b0, 1'b1, 1'b0, hot(4));
        drive(1'b0, 1'b1, 1'b1, hot(5));
        settle();
        check_now("t5_sticky_set", int'(bus.err_sticky), 1);
        check_now("t5_err_one", int'(bus.err_count), 1);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        settle();
        check_now("t5_sticky_clr", int'(bus.err_sticky), 0);
        check_now("t5_err_clr", int'(bus.err_count), 0);

        // Five revolutions with idle gaps, then reset while locked.
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h01);
        drive(1'b0, 1'b1, 1'b0, 8'h80);
        drive(1'b0, 1'b1, 1'b0, 8'h40);
        p = 6;
        for (int i = 0; i < 38; i++) begin
            if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'b0, 8'($urandom));
            p = (p + 7) % 8;
            drive(1'b0, 1'b1, 1'b0, hot(p));
        end
        settle();
        check_now("t6_rev5", int'(bus.rev_count), 5);
        check_now("t6_no_err", int'(bus.err_count), 0);
        drive(1'b1, 1'b1, 1'b0, hot((p + 7) % 8));
        settle();
        check_now("t6_rst_rev", int'(bus.rev_count), 0);
        check_now("t6_rst_locked", int'(bus.locked), 0);
        check_now("t6_rst_idx", int'(bus.phase_idx), 0);

        // Randomized traffic: mostly legal rotation with occasional corruption.
        p = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 999));
            rs = ($urandom_range(0, 9) != 0);
            rc = ($urandom_range(0, 49) == 0);
            rr = (r < 3);
            np = (p + 7) % 8;
            if (r < 20) begin
                ring = 8'($urandom);
            end else if (r < 35) begin
                np   = (p + 1) % 8;
                ring = hot(np);
            end else if (r < 45) begin
                np   = p;
                ring = hot(p);
            end else begin
                ring = hot(np);
            end
            drive(rr, rs, rc, ring);
            if (rs && ring == hot(np)) p = np;
        end

        repeat (3) @(posedge clk);
        #2;
        check_now("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
